// File: rtl/tune_sequencer_pkg.sv
// Shared definitions for the melody sequencer: ROM entry layout, rest code and FSM states.
package tune_sequencer_pkg;
    localparam logic [3:0] NOTE_REST = 4'hF;
    localparam int         ENTRY_W   = 9;
    localparam int         OCT_POS   = 8;
    localparam int         CODE_MSB  = 7;
    localparam int         CODE_LSB  = 4;
    localparam int         DUR_MSB   = 3;
    localparam int         DUR_LSB   = 0;
    localparam logic [3:0] DUR_END   = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_GAP
    } state_t;

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic oct, input logic [3:0] code,
                                                    input logic [3:0] dur);
        return {oct, code, dur};
    endfunction
endpackage

// File: rtl/tune_sequencer_rom.sv
// Melody ROM: built-in tune via case lookup, or a flat image supplied by the instantiator.
module melody_rom
    import tune_sequencer_pkg::*;
#(
    parameter int                                ADDR_W    = 5,
    parameter bit                                USE_IMAGE = 1'b0,
    parameter logic [(2**ADDR_W)*ENTRY_W-1:0]    ROM_IMAGE = '0
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [ENTRY_W-1:0] o_entry
);
    always_comb begin
        o_entry = '0;
        case (int'(i_addr))
            0:       o_entry = mk_entry(1'b0, 4'd1, 4'd1);
            1:       o_entry = mk_entry(1'b0, 4'd1, 4'd1);
            2:       o_entry = mk_entry(1'b0, 4'd5, 4'd1);
            3:       o_entry = mk_entry(1'b0, 4'd5, 4'd1);
            4:       o_entry = mk_entry(1'b0, 4'd6, 4'd1);
            5:       o_entry = mk_entry(1'b0, 4'd6, 4'd1);
            6:       o_entry = mk_entry(1'b0, 4'd5, 4'd2);
            7:       o_entry = mk_entry(1'b0, NOTE_REST, 4'd1);
            8:       o_entry = mk_entry(1'b0, 4'd4, 4'd1);
            9:       o_entry = mk_entry(1'b0, 4'd4, 4'd1);
            10:      o_entry = mk_entry(1'b0, 4'd3, 4'd1);
            11:      o_entry = mk_entry(1'b0, 4'd3, 4'd1);
            12:      o_entry = mk_entry(1'b0, 4'd2, 4'd1);
            13:      o_entry = mk_entry(1'b0, 4'd2, 4'd1);
            14:      o_entry = mk_entry(1'b0, 4'd1, 4'd2);
            default: o_entry = '0;
        endcase
        if (USE_IMAGE) o_entry = ROM_IMAGE[int'(i_addr)*ENTRY_W +: ENTRY_W];
    end
endmodule

// File: rtl/tune_sequencer.sv
// Melody playback FSM feeding the buzzer, with strict keypad priority that freezes playback.
module tune_sequencer
    import tune_sequencer_pkg::*;
#(
    parameter int                             BEAT_CYCLES   = 12_500_000,
    parameter int                             GAP_CYCLES    = 500_000,
    parameter int                             ADDR_W        = 5,
    parameter bit                             ROM_USE_IMAGE = 1'b0,
    parameter logic [(2**ADDR_W)*ENTRY_W-1:0] ROM_IMAGE     = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop_en,
    input  logic              i_key_valid,
    input  logic [3:0]        i_key_num,
    input  logic              i_key_high,
    output logic [3:0]        o_buzz_num,
    output logic              o_buzz_high,
    output logic              o_buzz_sw,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_note_idx
);
    localparam int                CYC_W    = $clog2(BEAT_CYCLES + 1);
    localparam int                GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
    logic [3:0]          r_code, w_code_nxt;
    logic                r_oct, w_oct_nxt;
    logic [3:0]          r_beats, w_beats_nxt;
    logic [CYC_W-1:0]    r_cyc, w_cyc_nxt;
    logic [GAP_W-1:0]    r_gap, w_gap_nxt;
    logic                w_done_nxt;
    logic [ENTRY_W-1:0]  w_entry;
    logic [3:0]          w_entry_dur;
    logic [3:0]          w_num;
    logic                w_high, w_sw;
    logic [3:0]          r_buzz_num;
    logic                r_buzz_high, r_buzz_sw, r_busy, r_done;

    melody_rom #(
        .ADDR_W    (ADDR_W),
        .USE_IMAGE (ROM_USE_IMAGE),
        .ROM_IMAGE (ROM_IMAGE)
    ) u_rom (
        .i_addr  (r_idx),
        .o_entry (w_entry)
    );

    assign w_entry_dur = w_entry[DUR_MSB:DUR_LSB];

    // Keypad activity only freezes an active sequence; stop and start from IDLE still act.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_code_nxt  = r_code;
        w_oct_nxt   = r_oct;
        w_beats_nxt = r_beats;
        w_cyc_nxt   = r_cyc;
        w_gap_nxt   = r_gap;
        w_done_nxt  = 1'b0;
        if (i_stop) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_beats_nxt = '0;
            w_cyc_nxt   = '0;
            w_gap_nxt   = '0;
        end else if (r_state == ST_IDLE) begin
            if (i_start) begin
                w_state_nxt = ST_FETCH;
                w_idx_nxt   = '0;
            end
        end else if (!i_key_valid) begin
            case (r_state)
                ST_FETCH: begin
                    if (w_entry_dur == DUR_END) begin
                        if (i_loop_en) begin
                            w_idx_nxt   = '0;
                            w_state_nxt = ST_FETCH;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_code_nxt  = w_entry[CODE_MSB:CODE_LSB];
                        w_oct_nxt   = w_entry[OCT_POS];
                        w_beats_nxt = w_entry_dur;
                        w_cyc_nxt   = '0;
                        w_state_nxt = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (r_cyc == CYC_LAST) begin
                        w_cyc_nxt   = '0;
                        w_beats_nxt = r_beats - 4'd1;
                        if (r_beats == 4'd1) begin
                            w_gap_nxt   = '0;
                            w_state_nxt = ST_GAP;
                        end
                    end else begin
                        w_cyc_nxt = r_cyc + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        w_gap_nxt = '0;
                        if (r_idx == IDX_LAST) begin
                            if (i_loop_en) begin
                                w_idx_nxt   = '0;
                                w_state_nxt = ST_FETCH;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_idx_nxt   = r_idx + 1'b1;
                            w_state_nxt = ST_FETCH;
                        end
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Buzzer drive reflects the state being entered, so every output lags its cause by one clock.
    always_comb begin
        w_num  = NOTE_REST;
        w_high = 1'b0;
        w_sw   = 1'b1;
        if (i_key_valid) begin
            w_num  = i_key_num;
            w_high = i_key_high;
            w_sw   = (i_key_num == NOTE_REST);
        end else if (w_state_nxt == ST_PLAY) begin
            w_num  = w_code_nxt;
            w_high = w_oct_nxt;
            w_sw   = (w_code_nxt == NOTE_REST);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_code      <= NOTE_REST;
            r_oct       <= 1'b0;
            r_beats     <= '0;
            r_cyc       <= '0;
            r_gap       <= '0;
            r_buzz_num  <= NOTE_REST;
            r_buzz_high <= 1'b0;
            r_buzz_sw   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_code      <= w_code_nxt;
            r_oct       <= w_oct_nxt;
            r_beats     <= w_beats_nxt;
            r_cyc       <= w_cyc_nxt;
            r_gap       <= w_gap_nxt;
            r_buzz_num  <= w_num;
            r_buzz_high <= w_high;
            r_buzz_sw   <= w_sw;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
        end
    end

    assign o_buzz_num  = r_buzz_num;
    assign o_buzz_high = r_buzz_high;
    assign o_buzz_sw   = r_buzz_sw;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_note_idx  = r_idx;
endmodule

// File: tb/tb_tune_sequencer.sv
// Bench: two sequencers (short tune, full 32-entry tune) against a timeline-based playback model.
module tb_tune_sequencer;
    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam int MAXL = 2048;

    function automatic logic [8:0] rom_ent(input bit b, input int i);
        logic [8:0] r;
        logic [3:0] code, dur;
        r = 9'd0;
        if (!b) begin
            case (i)
                0:       r = {1'b1, 4'h1, 4'd2};
                1:       r = {1'b0, 4'h0, 4'd1};
                2:       r = {1'b0, 4'hF, 4'd1};
                default: r = 9'd0;
            endcase
        end else begin
            code = (i % 7 == 3) ? 4'hF : 4'(i % 10);
            dur  = (i % 3 == 0) ? 4'd2 : 4'd1;
            r    = {i[0], code, dur};
        end
        return r;
    endfunction

    function automatic logic [32*9-1:0] build_img(input bit b);
        logic [32*9-1:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i*9 +: 9] = rom_ent(b, i);
        return v;
    endfunction

    localparam logic [32*9-1:0] IMG_A = build_img(1'b0);
    localparam logic [32*9-1:0] IMG_B = build_img(1'b1);

    logic       i_clk, i_rst_n, i_start, i_stop, i_loop_en, i_key_valid, i_key_high;
    logic [3:0] i_key_num;
    logic [3:0] a_num, b_num;
    logic       a_high, a_sw, a_busy, a_done, b_high, b_sw, b_busy, b_done;
    logic [4:0] a_idx, b_idx;
    logic [12:0] got [2];

    tune_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .ADDR_W(5),
                     .ROM_USE_IMAGE(1'b1), .ROM_IMAGE(IMG_A)) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_loop_en(i_loop_en), .i_key_valid(i_key_valid), .i_key_num(i_key_num),
        .i_key_high(i_key_high), .o_buzz_num(a_num), .o_buzz_high(a_high),
        .o_buzz_sw(a_sw), .o_busy(a_busy), .o_done(a_done), .o_note_idx(a_idx));

    tune_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .ADDR_W(5),
                     .ROM_USE_IMAGE(1'b1), .ROM_IMAGE(IMG_B)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_loop_en(i_loop_en), .i_key_valid(i_key_valid), .i_key_num(i_key_num),
        .i_key_high(i_key_high), .o_buzz_num(b_num), .o_buzz_high(b_high),
        .o_buzz_sw(b_sw), .o_busy(b_busy), .o_done(b_done), .o_note_idx(b_idx));

    assign got[0] = {a_sw, a_num, a_high, a_busy, a_done, a_idx};
    assign got[1] = {b_sw, b_num, b_high, b_busy, b_done, b_idx};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Model: one pass of a melody unrolled into per-cycle slots; playback is a cursor into it.
    typedef struct packed {
        logic       play;
        logic [3:0] code;
        logic       oct;
        logic [4:0] idx;
    } slot_t;

    slot_t       tl [2][MAXL];
    int          len [2];
    bit          m_act [2];
    int          m_p [2];
    logic [4:0]  m_iidx [2];
    bit          m_done [2];
    logic [12:0] m_exp [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic build_tl(input int d);
        logic [8:0] e;
        int         dur;
        len[d] = 0;
        for (int i = 0; i < 32; i++) begin
            e   = rom_ent(d[0], i);
            dur = int'(e[3:0]);
            tl[d][len[d]] = '{1'b0, 4'hF, 1'b0, 5'(i)}; len[d]++;
            if (dur == 0) break;
            for (int k = 0; k < dur * BEAT; k++) begin
                tl[d][len[d]] = '{1'b1, e[7:4], e[8], 5'(i)}; len[d]++;
            end
            for (int k = 0; k < GAP; k++) begin
                tl[d][len[d]] = '{1'b0, 4'hF, 1'b0, 5'(i)}; len[d]++;
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin m_act[d] = 0; m_iidx[d] = '0; m_p[d] = 0; end
    endtask

    task automatic model_step(input int d, input bit st, input bit sp, input bit kv,
                              input logic [3:0] kn, input bit kh);
        slot_t      s;
        logic       sw, high;
        logic [3:0] num;
        m_done[d] = 0;
        if (sp) begin
            m_act[d] = 0; m_iidx[d] = '0;
        end else if (!m_act[d]) begin
            if (st) begin m_act[d] = 1; m_p[d] = 0; end
        end else if (!kv) begin
            if (m_p[d] == len[d] - 1) begin
                if (i_loop_en) m_p[d] = 0;
                else begin
                    m_act[d] = 0; m_iidx[d] = tl[d][m_p[d]].idx; m_done[d] = 1;
                end
            end else m_p[d]++;
        end
        s = tl[d][m_p[d]];
        sw = 1'b1; num = 4'hF; high = 1'b0;
        if (kv) begin
            num = kn; high = kh; sw = (kn == 4'hF);
        end else if (m_act[d] && s.play) begin
            num = s.code; high = s.oct; sw = (s.code == 4'hF);
        end
        m_exp[d] = {sw, num, high, m_act[d], m_done[d], m_act[d] ? s.idx : m_iidx[d]};
    endtask

    task automatic step(input bit st, input bit sp, input bit kv, input logic [3:0] kn,
                        input bit kh);
        i_start = st; i_stop = sp; i_key_valid = kv; i_key_num = kn; i_key_high = kh;
        @(posedge i_clk); #1;
        for (int d = 0; d < 2; d++) begin
            model_step(d, st, sp, kv, kn, kh);
            chk(d == 0 ? "model_a" : "model_b", 32'(got[d]), 32'(m_exp[d]));
        end
        i_start = 0; i_stop = 0;
    endtask

    typedef struct {
        bit         st, sp, kv;
        logic [3:0] kn;
        bit         kh;
        logic [12:0] e;
    } vec_t;

    vec_t vt [11];
    int   nd_a, nd_b, pos_a, snd, n1, n5;
    logic [4:0] idx_b;
    bit   kv_r;
    logic [3:0] kn_r;
    bit   kh_r;

    initial begin
        vt[0]  = '{0, 0, 0, 4'h0, 0, {1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 5'd0}};
        vt[1]  = '{0, 0, 1, 4'h5, 0, {1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 5'd0}};
        vt[2]  = '{0, 0, 1, 4'hC, 1, {1'b0, 4'hC, 1'b1, 1'b0, 1'b0, 5'd0}};
        vt[3]  = '{0, 0, 1, 4'hF, 1, {1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 5'd0}};
        vt[4]  = '{1, 0, 0, 4'h0, 0, {1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 5'd0}};
        vt[5]  = '{0, 0, 0, 4'h0, 0, {1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 5'd0}};
        vt[6]  = '{1, 0, 0, 4'h0, 0, {1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 5'd0}};
        vt[7]  = '{0, 0, 1, 4'h7, 0, {1'b0, 4'h7, 1'b0, 1'b1, 1'b0, 5'd0}};
        vt[8]  = '{0, 0, 0, 4'h0, 0, {1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 5'd0}};
        vt[9]  = '{0, 1, 0, 4'h0, 0, {1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 5'd0}};
        vt[10] = '{0, 0, 0, 4'h0, 0, {1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 5'd0}};

        build_tl(0); build_tl(1);
        i_rst_n = 1; i_start = 0; i_stop = 0; i_loop_en = 0;
        i_key_valid = 0; i_key_num = 0; i_key_high = 0;
        #2 i_rst_n = 0;
        #1;
        chk("reset_a", 32'(got[0]), 32'({1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 5'd0}));
        chk("reset_b", 32'(got[1]), 32'({1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 5'd0}));
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst_n = 1;
        model_reset();

        for (int i = 0; i < 11; i++) begin
            step(vt[i].st, vt[i].sp, vt[i].kv, vt[i].kn, vt[i].kh);
            chk($sformatf("vec%0d", i), 32'(got[0]), 32'(vt[i].e));
        end

        // Full one-shot playback on both tunes.
        nd_a = 0; nd_b = 0; pos_a = -1; snd = 0; idx_b = '0;
        step(1, 0, 0, 4'h0, 0);
        for (int k = 1; k <= 300; k++) begin
            step(0, 0, 0, 4'h0, 0);
            if (a_done) begin nd_a++; pos_a = k; end
            if (!a_sw) snd++;
            if (b_done) begin nd_b++; idx_b = b_idx; end
        end
        chk("done_cnt_a", nd_a, 1);
        chk("done_pos_a", pos_a, 26);
        chk("sound_cyc_a", snd, 12);
        chk("done_cnt_b", nd_b, 1);
        chk("done_idx_b", 32'(idx_b), 31);

        // Looping: two identical periods, never a done pulse.
        i_loop_en = 1; nd_a = 0; snd = 0;
        step(1, 0, 0, 4'h0, 0);
        for (int k = 1; k <= 60; k++) begin
            step(0, 0, 0, 4'h0, 0);
            if (a_done) nd_a++;
            if (k <= 52 && !a_sw) snd++;
        end
        chk("loop_done_a", nd_a, 0);
        chk("loop_sound_a", snd, 24);
        step(0, 1, 0, 4'h0, 0);
        i_loop_en = 0;

        // Keypad interrupts note 0 for 3 cycles; note 0 keeps all 8 of its cycles.
        n1 = 0; n5 = 0;
        step(1, 0, 0, 4'h0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 4'h0, 0);
            if (!a_sw && a_num == 4'h1 && a_high) n1++;
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 4'h5, 0);
            if (!a_sw && a_num == 4'h5 && !a_high) n5++;
        end
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 4'h0, 0);
            if (!a_sw && a_num == 4'h1 && a_high) n1++;
        end
        chk("key_note5", n5, 3);
        chk("resume_note1", n1, 8);
        step(0, 1, 0, 4'h0, 0);

        // stop together with start during the gap of note 0.
        step(1, 0, 0, 4'h0, 0);
        for (int k = 0; k < 9; k++) step(0, 0, 0, 4'h0, 0);
        step(1, 1, 0, 4'h0, 0);
        chk("stopstart_a", 32'(got[0]), 32'({1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 5'd0}));
        for (int k = 0; k < 3; k++) step(0, 0, 0, 4'h0, 0);

        // Asynchronous reset mid-PLAY.
        step(1, 0, 0, 4'h0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 4'h0, 0);
        #2 i_rst_n = 0;
        #1;
        chk("arst_sw_busy_a", 32'({a_sw, a_busy}), 32'(2'b10));
        chk("arst_sw_busy_b", 32'({b_sw, b_busy}), 32'(2'b10));
        @(posedge i_clk); #1;
        i_rst_n = 1;
        model_reset();
        for (int k = 0; k < 5; k++) step(0, 0, 0, 4'h0, 0);
        chk("post_rst_idle", 32'({a_busy, b_busy}), 0);
        step(1, 0, 0, 4'h0, 0);

        // Random traffic against the model.
        kv_r = 0; kn_r = 0; kh_r = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 11) == 0) kv_r = ~kv_r;
            if ($urandom_range(0, 3) == 0) begin kn_r = 4'($urandom_range(0, 15)); kh_r = 1'($urandom); end
            if ($urandom_range(0, 299) == 0) i_loop_en = ~i_loop_en;
            step($urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0, kv_r, kn_r, kh_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
